// File: rtl/tlight_ctrl.sv
// tlight_ctrl: two-road junction controller. NS rests on GREEN and yields to a
// latched EW request once its minimum green has elapsed; an emergency forces
// every GREEN through YELLOW into an all-RED hold, then returns to NS GREEN.

typedef enum logic [2:0] {
    L_OFF       = 3'd0,
    L_RED       = 3'd1,
    L_YELLOW    = 3'd2,
    L_GREEN     = 3'd3,
    L_PRE_GREEN = 3'd4
} lights_t;

module tlight_ctrl #(
    parameter int unsigned NS_MIN_GREEN = 3,
    parameter int unsigned EW_GREEN_CYC = 3,
    parameter int unsigned EMG_MIN_RED  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ew_sensor,
    input  logic       emgcy_sensor,
    output lights_t    ns_light,
    output lights_t    ew_light,
    output logic [1:0] ns_green_timer,
    output logic       ew_green_req,
    output logic [2:0] ctrl_state
);

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_INIT  = 3'd1,
        ST_NS_G  = 3'd2,
        ST_NS_Y  = 3'd3,
        ST_EW_G  = 3'd4,
        ST_EW_Y  = 3'd5,
        ST_EMG_Y = 3'd6,
        ST_EMG_R = 3'd7
    } state_t;

    localparam logic [1:0] NS_MIN   = 2'(NS_MIN_GREEN);
    localparam logic [3:0] EW_LAST  = 4'(EW_GREEN_CYC - 1);
    localparam logic [3:0] EMG_LAST = 4'(EMG_MIN_RED - 1);

    state_t     state;
    state_t     next_state;
    logic [3:0] ew_cnt;
    logic [3:0] emg_cnt;
    lights_t    ns_next;
    lights_t    ew_next;
    logic [1:0] timer_next;
    logic [3:0] ew_cnt_next;
    logic [3:0] emg_cnt_next;
    logic       req_next;
    logic       emg_trig;
    logic       sensors_live;

    assign ctrl_state   = state;
    // Only the four traffic phases can be interrupted by an emergency.
    assign emg_trig     = emgcy_sensor &&
                          (state inside {ST_NS_G, ST_NS_Y, ST_EW_G, ST_EW_Y});
    assign sensors_live = !(state inside {ST_OFF, ST_INIT});

    // State register plus registered lamps, timers and request latch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_OFF;
            ns_light       <= L_OFF;
            ew_light       <= L_OFF;
            ns_green_timer <= '0;
            ew_green_req   <= 1'b0;
            ew_cnt         <= '0;
            emg_cnt        <= '0;
        end else begin
            state          <= next_state;
            ns_light       <= ns_next;
            ew_light       <= ew_next;
            ns_green_timer <= timer_next;
            ew_green_req   <= req_next;
            ew_cnt         <= ew_cnt_next;
            emg_cnt        <= emg_cnt_next;
        end
    end

    // Next-state selection; an emergency overrides every traffic transition.
    always_comb begin
        next_state = state;
        case (state)
            ST_OFF:   next_state = ST_INIT;
            ST_INIT:  next_state = ST_NS_G;
            ST_NS_G:  if (ew_green_req && (ns_green_timer >= NS_MIN)) next_state = ST_NS_Y;
            ST_NS_Y:  next_state = ST_EW_G;
            ST_EW_G:  if (ew_cnt == EW_LAST) next_state = ST_EW_Y;
            ST_EW_Y:  next_state = ST_NS_G;
            ST_EMG_Y: next_state = ST_EMG_R;
            ST_EMG_R: if (!emgcy_sensor && (emg_cnt >= EMG_LAST)) next_state = ST_NS_G;
            default:  next_state = ST_OFF;
        endcase
        if (emg_trig) next_state = ST_EMG_Y;
    end

    // Decode of the upcoming state into lamp, timer, counter and request values.
    always_comb begin
        ns_next      = L_OFF;
        ew_next      = L_OFF;
        timer_next   = '0;
        ew_cnt_next  = '0;
        emg_cnt_next = '0;
        req_next     = ew_green_req;

        case (next_state)
            ST_OFF:   begin ns_next = L_OFF;    ew_next = L_OFF;    end
            ST_INIT:  begin ns_next = L_RED;    ew_next = L_RED;    end
            ST_NS_G:  begin ns_next = L_GREEN;  ew_next = L_RED;    end
            ST_NS_Y:  begin ns_next = L_YELLOW; ew_next = L_RED;    end
            ST_EW_G:  begin ns_next = L_RED;    ew_next = L_GREEN;  end
            ST_EW_Y:  begin ns_next = L_RED;    ew_next = L_YELLOW; end
            // The emergency YELLOW depends on what each lamp shows now, so it is
            // derived from the current lamp registers rather than the state.
            ST_EMG_Y: begin
                ns_next = (ns_light == L_GREEN) ? L_YELLOW : ns_light;
                ew_next = (ew_light == L_GREEN) ? L_YELLOW : ew_light;
            end
            ST_EMG_R: begin ns_next = L_RED;    ew_next = L_RED;    end
            default:  begin ns_next = L_OFF;    ew_next = L_OFF;    end
        endcase

        if ((next_state == ST_NS_G) && (state == ST_NS_G))
            timer_next = (ns_green_timer == 2'd3) ? 2'd3 : ns_green_timer + 2'd1;

        if ((next_state == ST_EW_G) && (state == ST_EW_G))
            ew_cnt_next = ew_cnt + 4'd1;

        // A sensor sample during the all-RED hold restarts the minimum count.
        if ((next_state == ST_EMG_R) && (state == ST_EMG_R) && !emgcy_sensor)
            emg_cnt_next = (emg_cnt == 4'hF) ? emg_cnt : emg_cnt + 4'd1;

        if (ew_sensor && sensors_live && (state != ST_EW_G))
            req_next = 1'b1;
        if ((next_state == ST_EW_G) && (state != ST_EW_G))
            req_next = 1'b0;
    end

endmodule

// File: tb/tb_tlight_ctrl.sv
// tb_tlight_ctrl: directed literal sequences plus randomized sensors, checked
// every cycle against a lamp-level behavioural model of the controller.

module tb_tlight_ctrl;

    localparam int NS_MIN_GREEN = 3;
    localparam int EW_GREEN_CYC = 3;
    localparam int EMG_MIN_RED  = 2;

    localparam int OFF       = 0;
    localparam int RED       = 1;
    localparam int YELLOW    = 2;
    localparam int GREEN     = 3;
    localparam int PRE_GREEN = 4;

    logic       clk          = 1'b0;
    logic       reset_n      = 1'b0;
    logic       ew_sensor    = 1'b0;
    logic       emgcy_sensor = 1'b0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [1:0] ns_green_timer;
    logic       ew_green_req;
    logic [2:0] ctrl_state;

    tlight_ctrl #(
        .NS_MIN_GREEN(NS_MIN_GREEN),
        .EW_GREEN_CYC(EW_GREEN_CYC),
        .EMG_MIN_RED (EMG_MIN_RED)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ew_sensor     (ew_sensor),
        .emgcy_sensor  (emgcy_sensor),
        .ns_light      (ns_light),
        .ew_light      (ew_light),
        .ns_green_timer(ns_green_timer),
        .ew_green_req  (ew_green_req),
        .ctrl_state    (ctrl_state)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int em_hold = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Lamp-level model: phase is read off the lamp pair, dwell times are
    // differences of absolute cycle stamps.
    typedef struct {
        int ns;
        int ew;
        bit on;
        bit init;
        bit emg;
        bit req;
        int ns_start;
        int ew_start;
        int last_em;
        bit lat_pend;
        int lat_deadline;
    } model_t;

    model_t m = '{default: 0};

    function automatic model_t model_step(model_t c, bit ew, bit em, int t);
        model_t n = c;
        bit ew_green_now = (c.ew == GREEN);
        bit live = c.on && !c.init;
        bit enter_ew = 1'b0;
        if (!c.on) begin
            n.on = 1; n.init = 1; n.ns = RED; n.ew = RED;
        end else if (c.init) begin
            n.init = 0; n.ns = GREEN; n.ns_start = t + 1;
        end else if (c.emg) begin
            if (c.ns == YELLOW || c.ew == YELLOW) begin
                n.ns = RED; n.ew = RED; n.last_em = t;
            end else if (em) begin
                n.last_em = t;
            end else if (t - c.last_em >= EMG_MIN_RED) begin
                n.emg = 0; n.ns = GREEN; n.ns_start = t + 1;
            end
        end else if (em) begin
            n.emg = 1;
            if (c.ns == GREEN) n.ns = YELLOW;
            if (c.ew == GREEN) n.ew = YELLOW;
            n.lat_pend = 0;
        end else if (c.ns == GREEN) begin
            if (c.req && (t - c.ns_start >= NS_MIN_GREEN)) n.ns = YELLOW;
        end else if (c.ns == YELLOW) begin
            n.ns = RED; n.ew = GREEN; n.ew_start = t + 1; enter_ew = 1;
        end else if (c.ew == GREEN) begin
            if (t - c.ew_start + 1 >= EW_GREEN_CYC) n.ew = YELLOW;
        end else begin
            n.ew = RED; n.ns = GREEN; n.ns_start = t + 1;
        end

        if (enter_ew) n.req = 0;
        else if (ew && live && !ew_green_now) n.req = 1;

        if (ew && live && !c.emg && !em && !ew_green_now && !c.lat_pend) begin
            n.lat_pend = 1; n.lat_deadline = t + 12;
        end
        if (n.ew == GREEN) n.lat_pend = 0;
        return n;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) m <= '{default: 0};
        else          m <= model_step(m, ew_sensor, emgcy_sensor, cyc);
        cyc <= cyc + 1;
    end

    logic [2:0] prev_ns = 3'd0;
    logic [2:0] prev_ew = 3'd0;

    // Per-cycle comparison against the model plus lamp invariants.
    always @(negedge clk) begin : cmp
        int exp_tm;
        if (!reset_n) begin
            chk("rst_ns_light", int'(ns_light), OFF);
            chk("rst_ew_light", int'(ew_light), OFF);
            chk("rst_timer", int'(ns_green_timer), 0);
            chk("rst_req", int'(ew_green_req), 0);
            chk("rst_ctrl_state", int'(ctrl_state), 0);
        end else begin
            exp_tm = 0;
            if (m.ns == GREEN) exp_tm = (cyc - m.ns_start > 3) ? 3 : cyc - m.ns_start;
            chk("ns_light", int'(ns_light), m.ns);
            chk("ew_light", int'(ew_light), m.ew);
            chk("ns_green_timer", int'(ns_green_timer), exp_tm);
            chk("ew_green_req", int'(ew_green_req), int'(m.req));
            chk("inv_both_green", int'(ns_light == 3'(GREEN) && ew_light == 3'(GREEN)), 0);
            chk("inv_green_yellow", int'((ns_light == 3'(GREEN) && ew_light == 3'(YELLOW)) ||
                                         (ew_light == 3'(GREEN) && ns_light == 3'(YELLOW))), 0);
            chk("inv_pre_green", int'(ns_light == 3'(PRE_GREEN) || ew_light == 3'(PRE_GREEN)), 0);
            chk("inv_ns_green_to_red", int'(prev_ns == 3'(GREEN) && ns_light == 3'(RED)), 0);
            chk("inv_ew_green_to_red", int'(prev_ew == 3'(GREEN) && ew_light == 3'(RED)), 0);
            chk("ew_latency", int'(m.lat_pend && (cyc > m.lat_deadline)), 0);
        end
        prev_ns <= reset_n ? ns_light : 3'd0;
        prev_ew <= reset_n ? ew_light : 3'd0;
    end

    // Hand-derived expectations for cycles 0..38 after reset release.
    int tab_ns[39] = '{0,1,3,3,3,3,2,1,1,1, 1,3,3,3,3,2,1,1,1,1,
                       1,3,3,2,1,1,1,1,1,3, 3,3,3,2,1,1,1,1,3};
    int tab_ew[39] = '{0,1,1,1,1,1,1,3,3,3, 2,1,1,1,1,1,3,3,2,1,
                       1,1,1,1,1,1,1,1,1,1, 1,1,1,1,3,3,3,2,1};
    int tab_tm[39] = '{0,0,0,1,2,3,0,0,0,0, 0,0,1,2,3,0,0,0,0,0,
                       0,0,1,0,0,0,0,0,0,0, 1,2,3,0,0,0,0,0,0};
    int tab_rq[39] = '{0,0,0,1,1,1,1,0,0,0, 0,0,0,1,1,1,0,0,0,0,
                       0,0,0,0,0,1,1,1,1,1, 1,1,1,1,0,0,0,0,0};
    int stim_ew[39] = '{0,0,1,0,0,0,0,0,0,0, 0,0,1,0,0,0,0,0,0,0,
                        0,0,0,0,1,0,0,0,0,0, 0,0,0,0,0,0,0,0,0};
    int stim_em[39] = '{0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1,0,0,
                        0,0,1,1,1,1,1,0,0,0, 0,0,0,0,0,0,0,0,0};

    // Caller is positioned #1 after the negedge of cycle 0.
    task automatic run_table(input int rows);
        for (int c = 0; c < rows; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            chk("tab_ns_light", int'(ns_light), tab_ns[c]);
            chk("tab_ew_light", int'(ew_light), tab_ew[c]);
            chk("tab_timer", int'(ns_green_timer), tab_tm[c]);
            chk("tab_req", int'(ew_green_req), tab_rq[c]);
            ew_sensor    = (stim_ew[c] != 0);
            emgcy_sensor = (stim_em[c] != 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("hold_ctrl_state", int'(ctrl_state), 0);
        chk("hold_ns_light", int'(ns_light), OFF);
        reset_n = 1'b1;
        run_table(39);

        // Reach NS YELLOW, then drop reset in the middle of that cycle.
        @(negedge clk); #1; ew_sensor = 1'b1;
        @(negedge clk); #1; ew_sensor = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("pre_reset_ns_yellow", int'(ns_light), YELLOW);
        chk("pre_reset_req", int'(ew_green_req), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_ns_off", int'(ns_light), OFF);
        chk("async_ew_off", int'(ew_light), OFF);
        chk("async_req_clear", int'(ew_green_req), 0);
        chk("async_state_off", int'(ctrl_state), 0);
        @(posedge clk);
        @(negedge clk); #1;
        reset_n = 1'b1;
        run_table(12);
        ew_sensor    = 1'b0;
        emgcy_sensor = 1'b0;

        for (int i = 0; i < 20000; i++) begin
            @(negedge clk); #1;
            if ($urandom_range(0, 2499) == 0) begin
                ew_sensor    = 1'b0;
                emgcy_sensor = 1'b0;
                em_hold      = 0;
                @(posedge clk);
                #($urandom_range(1, 3));
                reset_n = 1'b0;
                @(posedge clk);
                @(negedge clk); #1;
                reset_n = 1'b1;
            end
            ew_sensor = ($urandom_range(0, 5) == 0);
            if (em_hold == 0 && $urandom_range(0, 39) == 0) em_hold = $urandom_range(1, 6);
            emgcy_sensor = (em_hold != 0);
            if (em_hold != 0) em_hold--;
        end

        ew_sensor    = 1'b0;
        emgcy_sensor = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
